// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - constants, font ROM and decode result type for the display snoop
package hex_display_pkg;

  localparam int NUM_CHARS     = 16;
  localparam int DOTS_PER_CHAR = 40;
  localparam int CTRL_BITS     = 32;
  localparam int FRAME_BITS    = NUM_CHARS * DOTS_PER_CHAR;

  // Hex font used by the display driver, entry k is the 40-dot image of digit k.
  // Listed from 'F' down to '0' so that GLYPH_ROM[k] selects digit k.
  localparam logic [15:0][39:0] GLYPH_ROM = {
    40'h7F_09_09_09_01,  // F
    40'h7F_49_49_49_41,  // E
    40'h7F_41_41_41_3E,  // D
    40'h3E_41_41_41_22,  // C
    40'h7F_49_49_49_36,  // B
    40'h7E_09_09_09_7E,  // A
    40'h06_49_49_29_1E,  // 9
    40'h36_49_49_49_36,  // 8
    40'h01_71_09_05_03,  // 7
    40'h3C_4A_49_49_30,  // 6
    40'h27_45_45_45_39,  // 5
    40'h18_14_12_7F_10,  // 4
    40'h22_41_49_49_36,  // 3
    40'h62_51_49_49_46,  // 2
    40'h00_42_7F_40_00,  // 1
    40'h3E_51_49_45_3E   // 0
  };

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       lit;
    logic       err;
  } glyph_dec_t;

endpackage

// File: rtl/hex_glyph_decode.sv
// rtl/hex_glyph_decode.sv - combinational 40-dot character to hex nibble decoder
module hex_glyph_decode
  import hex_display_pkg::*;
(
  input  logic [39:0] i_dots,
  output glyph_dec_t  o_dec
);

  // lit beats blank beats glyph match; anything else is flagged unknown
  always_comb begin
    o_dec = '0;
    if (&i_dots) begin
      o_dec.lit = 1'b1;
    end else if (~|i_dots) begin
      o_dec.blank = 1'b1;
    end else begin
      o_dec.err = 1'b1;
      for (int k = 0; k < 16; k++) begin
        if (i_dots == GLYPH_ROM[k]) begin
          o_dec.nibble = k[3:0];
          o_dec.err    = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/hex_display_snoop.sv
// rtl/hex_display_snoop.sv - passive deserializer/decoder for the labkit dot-matrix display bus
module hex_display_snoop
  import hex_display_pkg::glyph_dec_t;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int NUM_CHARS     = 16,
  parameter int DOTS_PER_CHAR = 40,
  parameter int CTRL_BITS     = 32
) (
  input  logic                   clock_27mhz,
  input  logic                   reset,
  input  logic                   disp_clock,
  input  logic                   disp_data_out,
  input  logic                   disp_rs,
  input  logic                   disp_ce_b,
  input  logic                   disp_reset_b,
  output logic [4*NUM_CHARS-1:0] hex_data,
  output logic [NUM_CHARS-1:0]   blank_flags,
  output logic [NUM_CHARS-1:0]   lit_flags,
  output logic [NUM_CHARS-1:0]   glyph_err,
  output logic [CTRL_BITS-1:0]   ctrl_word,
  output logic                   frame_stb,
  output logic                   ctrl_stb,
  output logic                   frame_err,
  output logic                   reset_seen
);

  localparam int                IDX_W     = $clog2(NUM_CHARS);
  localparam logic [9:0]        FRAME_CNT = 10'(NUM_CHARS * DOTS_PER_CHAR);
  localparam logic [9:0]        CTRL_CNT  = 10'(CTRL_BITS);
  localparam logic [5:0]        LAST_DOT  = 6'(DOTS_PER_CHAR - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_CHARS - 1);

  // bus vector layout {reset_b, ce_b, rs, data, clock}; idle bus is reset_b=1, ce_b=1
  localparam int         B_CLK  = 0;
  localparam int         B_DAT  = 1;
  localparam int         B_RS   = 2;
  localparam int         B_CEB  = 3;
  localparam int         B_RSTB = 4;
  localparam logic [4:0] BUS_IDLE  = 5'b11000;
  localparam logic [2:0] HIST_IDLE = 3'b110;

  logic [4:0]             r_sync [SYNC_STAGES];
  logic [2:0]             r_hist;  // {reset_b, ce_b, clock} one cycle older than synced
  logic [4:0]             w_bus_in;
  logic [4:0]             w_sync;
  logic                   w_bus_rst;
  logic                   w_sclk_rise;
  logic                   w_latch;
  logic                   w_reset_fall;
  logic                   w_first;
  logic                   w_rs_eff;

  logic [DOTS_PER_CHAR-1:0] r_shift;
  logic [9:0]             r_total_cnt;
  logic [5:0]             r_char_cnt;
  logic [IDX_W-1:0]       r_char_idx;
  logic                   r_rs;
  logic                   r_err;
  logic                   r_dec_pend;
  logic                   r_latch_pend;

  logic [4*NUM_CHARS-1:0] r_stg_hex;
  logic [NUM_CHARS-1:0]   r_stg_blank;
  logic [NUM_CHARS-1:0]   r_stg_lit;
  logic [NUM_CHARS-1:0]   r_stg_gerr;
  logic [4*NUM_CHARS-1:0] w_hex_next;
  logic [NUM_CHARS-1:0]   w_blank_next;
  logic [NUM_CHARS-1:0]   w_lit_next;
  logic [NUM_CHARS-1:0]   w_gerr_next;
  glyph_dec_t             w_dec;

  assign w_bus_in = {disp_reset_b, disp_ce_b, disp_rs, disp_data_out, disp_clock};
  assign w_sync   = r_sync[SYNC_STAGES-1];

  // synchronizer chain on every bus input plus edge-detect history
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= BUS_IDLE;
      r_hist <= HIST_IDLE;
    end else begin
      r_sync[0] <= w_bus_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_hist <= {w_sync[B_RSTB], w_sync[B_CEB], w_sync[B_CLK]};
    end
  end

  assign w_bus_rst    = ~w_sync[B_RSTB];
  assign w_sclk_rise  = w_sync[B_CLK] & ~r_hist[0] & ~w_sync[B_CEB] & ~w_bus_rst;
  assign w_latch      = w_sync[B_CEB] & ~r_hist[1] & ~w_bus_rst;
  assign w_reset_fall = ~w_sync[B_RSTB] & r_hist[2];
  assign w_first      = (r_total_cnt == 10'd0);
  assign w_rs_eff     = w_first ? w_sync[B_RS] : r_rs;

  // shift register, bit counters and rs tracking; cleared by bus reset or a processed latch
  always_ff @(posedge clock_27mhz) begin
    if (reset || w_bus_rst || r_latch_pend) begin
      r_shift     <= '0;
      r_total_cnt <= '0;
      r_char_cnt  <= '0;
      r_rs        <= 1'b0;
      r_err       <= 1'b0;
      r_dec_pend  <= 1'b0;
    end else begin
      r_dec_pend <= 1'b0;
      if (w_sclk_rise) begin
        r_shift <= {r_shift[DOTS_PER_CHAR-2:0], w_sync[B_DAT]};
        if (r_total_cnt != 10'd1023) r_total_cnt <= r_total_cnt + 10'd1;
        if (w_first) r_rs <= w_sync[B_RS];
        else if (w_sync[B_RS] != r_rs) r_err <= 1'b1;
        if (r_char_cnt == LAST_DOT) begin
          r_char_cnt <= '0;
          // only the first full frame of dots is decoded
          r_dec_pend <= ~w_rs_eff && (r_total_cnt < FRAME_CNT);
        end else begin
          r_char_cnt <= r_char_cnt + 6'd1;
        end
      end
    end
  end

  hex_glyph_decode u_decode (
    .i_dots (r_shift),
    .o_dec  (w_dec)
  );

  // staging contents including the character being written this cycle
  always_comb begin
    w_hex_next   = r_stg_hex;
    w_blank_next = r_stg_blank;
    w_lit_next   = r_stg_lit;
    w_gerr_next  = r_stg_gerr;
    if (r_dec_pend) begin
      w_hex_next[{r_char_idx, 2'b00} +: 4] = w_dec.nibble;
      w_blank_next[r_char_idx]             = w_dec.blank;
      w_lit_next[r_char_idx]               = w_dec.lit;
      w_gerr_next[r_char_idx]              = w_dec.err;
    end
  end

  // staging registers and character slot pointer (counts down from the top, no wrap)
  always_ff @(posedge clock_27mhz) begin
    if (reset || w_bus_rst) begin
      r_stg_hex   <= '0;
      r_stg_blank <= '0;
      r_stg_lit   <= '0;
      r_stg_gerr  <= '0;
      r_char_idx  <= LAST_IDX;
    end else begin
      r_stg_hex   <= w_hex_next;
      r_stg_blank <= w_blank_next;
      r_stg_lit   <= w_lit_next;
      r_stg_gerr  <= w_gerr_next;
      if (r_latch_pend) r_char_idx <= LAST_IDX;
      else if (r_dec_pend && r_char_idx != '0) r_char_idx <= r_char_idx - 1'b1;
    end
  end

  // latch evaluation one cycle after detection, so a coincident final bit is counted
  always_ff @(posedge clock_27mhz) begin
    if (reset) begin
      hex_data     <= '0;
      blank_flags  <= '0;
      lit_flags    <= '0;
      glyph_err    <= '0;
      ctrl_word    <= '0;
      frame_stb    <= 1'b0;
      ctrl_stb     <= 1'b0;
      frame_err    <= 1'b0;
      reset_seen   <= 1'b0;
      r_latch_pend <= 1'b0;
    end else begin
      frame_stb    <= 1'b0;
      ctrl_stb     <= 1'b0;
      frame_err    <= 1'b0;
      reset_seen   <= w_reset_fall;
      r_latch_pend <= w_latch;
      if (r_latch_pend && !w_bus_rst && r_total_cnt != 10'd0) begin
        if (!r_rs) begin
          if (r_total_cnt == FRAME_CNT && !r_err) begin
            hex_data    <= w_hex_next;
            blank_flags <= w_blank_next;
            lit_flags   <= w_lit_next;
            glyph_err   <= w_gerr_next;
            frame_stb   <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          if (r_total_cnt == CTRL_CNT && !r_err) begin
            ctrl_word <= r_shift[CTRL_BITS-1:0];
            ctrl_stb  <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_display_snoop.sv
// tb/tb_hex_display_snoop.sv - directed self-checking bench for hex_display_snoop
module tb_hex_display_snoop;

  localparam int H = 3;  // display clock half period in system cycles

  logic        clock_27mhz   = 1'b0;
  logic        reset         = 1'b1;
  logic        disp_clock    = 1'b0;
  logic        disp_data_out = 1'b0;
  logic        disp_rs       = 1'b0;
  logic        disp_ce_b     = 1'b1;
  logic        disp_reset_b  = 1'b1;
  logic [63:0] hex_data;
  logic [15:0] blank_flags;
  logic [15:0] lit_flags;
  logic [15:0] glyph_err;
  logic [31:0] ctrl_word;
  logic        frame_stb;
  logic        ctrl_stb;
  logic        frame_err;
  logic        reset_seen;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_fstb = 0, n_cstb = 0, n_ferr = 0, n_rseen = 0;
  int f0, c0, e0, r0;
  int last_fstb_cyc = 0;
  int ce_cyc = 0;
  logic [639:0] fr;

  hex_display_snoop dut (
    .clock_27mhz   (clock_27mhz),
    .reset         (reset),
    .disp_clock    (disp_clock),
    .disp_data_out (disp_data_out),
    .disp_rs       (disp_rs),
    .disp_ce_b     (disp_ce_b),
    .disp_reset_b  (disp_reset_b),
    .hex_data      (hex_data),
    .blank_flags   (blank_flags),
    .lit_flags     (lit_flags),
    .glyph_err     (glyph_err),
    .ctrl_word     (ctrl_word),
    .frame_stb     (frame_stb),
    .ctrl_stb      (ctrl_stb),
    .frame_err     (frame_err),
    .reset_seen    (reset_seen)
  );

  always #5 clock_27mhz = ~clock_27mhz;

  always @(posedge clock_27mhz) cyc <= cyc + 1;

  always @(negedge clock_27mhz) begin
    if (frame_stb) begin
      n_fstb++;
      last_fstb_cyc = cyc;
    end
    if (ctrl_stb)   n_cstb++;
    if (frame_err)  n_ferr++;
    if (reset_seen) n_rseen++;
  end

  function automatic logic [39:0] font(input logic [3:0] k);
    case (k)
      4'h0: font = 40'h3E_51_49_45_3E;
      4'h1: font = 40'h00_42_7F_40_00;
      4'h2: font = 40'h62_51_49_49_46;
      4'h3: font = 40'h22_41_49_49_36;
      4'h4: font = 40'h18_14_12_7F_10;
      4'h5: font = 40'h27_45_45_45_39;
      4'h6: font = 40'h3C_4A_49_49_30;
      4'h7: font = 40'h01_71_09_05_03;
      4'h8: font = 40'h36_49_49_49_36;
      4'h9: font = 40'h06_49_49_29_1E;
      4'hA: font = 40'h7E_09_09_09_7E;
      4'hB: font = 40'h7F_49_49_49_36;
      4'hC: font = 40'h3E_41_41_41_22;
      4'hD: font = 40'h7F_41_41_41_3E;
      4'hE: font = 40'h7F_49_49_49_41;
      default: font = 40'h7F_09_09_09_01;
    endcase
  endfunction

  function automatic logic [639:0] build(input logic [63:0] hx);
    logic [639:0] f;
    for (int k = 0; k < 16; k++) f[40*k +: 40] = font(hx[4*k +: 4]);
    return f;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock_27mhz);
    #1;
  endtask

  task automatic snap();
    f0 = n_fstb; c0 = n_cstb; e0 = n_ferr; r0 = n_rseen;
  endtask

  task automatic begin_load(input logic rs);
    disp_rs   = rs;
    disp_ce_b = 1'b0;
    tick(H);
  endtask

  task automatic send_bit(input logic b);
    disp_data_out = b;
    tick(H);
    disp_clock = 1'b1;
    tick(H);
    disp_clock = 1'b0;
  endtask

  task automatic send_frame(input logic [639:0] f, input int n);
    for (int i = 0; i < n; i++) send_bit(f[639-i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic end_load();
    tick(H);
    disp_ce_b = 1'b1;
    ce_cyc    = cyc;
    tick(12);
  endtask

  task automatic chk_pulses(input string tag, input int fs, input int cs, input int fe);
    chk({tag, "_frame_stb"}, 64'(n_fstb - f0), 64'(fs));
    chk({tag, "_ctrl_stb"},  64'(n_cstb - c0), 64'(cs));
    chk({tag, "_frame_err"}, 64'(n_ferr - e0), 64'(fe));
  endtask

  initial begin
    tick(4);
    reset = 1'b0;
    tick(3);

    // reset state
    chk("rst_hex", hex_data, 64'h0);
    chk("rst_blank", {48'h0, blank_flags}, 64'h0);
    chk("rst_lit", {48'h0, lit_flags}, 64'h0);
    chk("rst_gerr", {48'h0, glyph_err}, 64'h0);
    chk("rst_ctrl", {32'h0, ctrl_word}, 64'h0);
    chk("rst_pulses", {60'h0, frame_stb, ctrl_stb, frame_err, reset_seen}, 64'h0);

    // power-up: blank frame then control word
    snap();
    begin_load(1'b0);
    send_frame('0, 640);
    end_load();
    chk_pulses("pwr", 1, 0, 0);
    chk("pwr_latency", 64'(last_fstb_cyc - ce_cyc), 64'd4);
    chk("pwr_blank", {48'h0, blank_flags}, 64'hFFFF);
    chk("pwr_hex", hex_data, 64'h0);
    chk("pwr_lit", {48'h0, lit_flags}, 64'h0);
    chk("pwr_gerr", {48'h0, glyph_err}, 64'h0);

    snap();
    begin_load(1'b1);
    send_word(32'h7F7F7F7F);
    end_load();
    chk_pulses("ctl", 0, 1, 0);
    chk("ctl_word", {32'h0, ctrl_word}, 64'h7F7F7F7F);
    chk("ctl_hex_kept", hex_data, 64'h0);

    // all sixteen glyphs
    snap();
    begin_load(1'b0);
    send_frame(build(64'h0123_4567_89AB_CDEF), 640);
    end_load();
    chk_pulses("hex", 1, 0, 0);
    chk("hex_data", hex_data, 64'h0123_4567_89AB_CDEF);
    chk("hex_blank", {48'h0, blank_flags}, 64'h0);
    chk("hex_lit", {48'h0, lit_flags}, 64'h0);
    chk("hex_gerr", {48'h0, glyph_err}, 64'h0);

    // char 5 all lit, char 9 blank
    fr = build(64'h0123_4567_89AB_CDEF);
    fr[40*5 +: 40] = '1;
    fr[40*9 +: 40] = '0;
    snap();
    begin_load(1'b0);
    send_frame(fr, 640);
    end_load();
    chk_pulses("lb", 1, 0, 0);
    chk("lb_lit", {48'h0, lit_flags}, 64'h0020);
    chk("lb_blank", {48'h0, blank_flags}, 64'h0200);
    chk("lb_hex", hex_data, 64'h0123_4507_890B_CDEF);
    chk("lb_gerr", {48'h0, glyph_err}, 64'h0);

    // char 0 is glyph '0' with one dot flipped
    fr = build(64'h0123_4567_89AB_CDEF);
    fr[39:0] = 40'h3E_51_49_45_3F;
    snap();
    begin_load(1'b0);
    send_frame(fr, 640);
    end_load();
    chk_pulses("ge", 1, 0, 0);
    chk("ge_gerr", {48'h0, glyph_err}, 64'h0001);
    chk("ge_hex", hex_data, 64'h0123_4567_89AB_CDE0);
    chk("ge_blank", {48'h0, blank_flags}, 64'h0);

    // short frame: 639 bits
    snap();
    begin_load(1'b0);
    send_frame(build(64'hFFFF_FFFF_FFFF_FFFF), 639);
    end_load();
    chk_pulses("short", 0, 0, 1);
    chk("short_hex_kept", hex_data, 64'h0123_4567_89AB_CDE0);

    // latch with no bits shifted
    snap();
    begin_load(1'b0);
    end_load();
    chk_pulses("empty", 0, 0, 0);

    // display reset mid-load, then a full frame in the same enable window
    snap();
    begin_load(1'b0);
    send_frame(build(64'h1111_1111_1111_1111), 200);
    disp_reset_b = 1'b0;
    tick(8);
    disp_reset_b = 1'b1;
    tick(8);
    chk("drst_seen", 64'(n_rseen - r0), 64'd1);
    send_frame(build(64'hFEDC_BA98_7654_3210), 640);
    end_load();
    chk_pulses("drst", 1, 0, 0);
    chk("drst_hex", hex_data, 64'hFEDC_BA98_7654_3210);
    chk("drst_gerr", {48'h0, glyph_err}, 64'h0);
    chk("drst_ctrl_kept", {32'h0, ctrl_word}, 64'h7F7F7F7F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hex_display_snoop.md
Name: hex_display_snoop

Overview:
- Passive receiver for the labkit dot-matrix display serial bus. It is the other end of the 16-hex-digit display driver.
- Oversamples disp_clock, disp_data_out, disp_rs, disp_ce_b and disp_reset_b with clock_27mhz, then deserializes the dot and control register loads.
- Decodes each 40-dot character back to a hex nibble, or to a blank / all-lit / unknown flag.
- Used for on-board self-test of display content and for bench checking of display drivers.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on every bus input.
- NUM_CHARS, 16, characters per dot-register frame.
- DOTS_PER_CHAR, 40, dots per character.
- CTRL_BITS, 32, control register length.

Ports:
- clock_27mhz  in  1  system clock
- reset  in  1  synchronous, active-high
- disp_clock  in  1  display shift clock (~500 kHz); display samples on its rising edge
- disp_data_out  in  1  serial dot/control data, MSB first
- disp_rs  in  1  0 = dot register, 1 = control register
- disp_ce_b  in  1  active-low chip enable; its rising edge latches the shifted data
- disp_reset_b  in  1  active-low display reset
- hex_data  out  64  decoded nibbles; char 15 in [63:60], char 0 in [3:0]
- blank_flags  out  16  char is all dots 0
- lit_flags  out  16  char is all dots 1
- glyph_err  out  16  char matches no hex glyph and is neither blank nor lit
- ctrl_word  out  32  last latched control word
- frame_stb  out  1  one-cycle pulse: dot frame accepted, outputs updated
- ctrl_stb  out  1  one-cycle pulse: ctrl_word updated
- frame_err  out  1  one-cycle pulse: latch with wrong bit count or rs change mid-load
- reset_seen  out  1  one-cycle pulse on disp_reset_b falling edge

Behaviour:
- Reset: all outputs 0; bit counter 0; shift register 0; staging registers cleared.
- Synchronization: every input passes SYNC_STAGES flops, plus one history flop for edge detection.
  - sclk_rise = synced disp_clock 0->1.
  - latch = synced disp_ce_b 0->1.
- Shift: on sclk_rise with synced ce_b = 0:
  - Shift data into a 40-bit shift register, left, LSB in; the first bit ends in [39].
  - Increment the 10-bit total bit count, saturating at 1023.
  - On the first bit of a load, record rs. Any later bit with a different rs sets a sticky err flag.
  - sclk_rise with ce_b = 1 is ignored.
- Per-character decode (dot load, rs = 0): when the per-char count reaches 40:
  - Decode the shift register combinationally.
  - Write into staging slot char_idx. char_idx starts at 15 per load and decrements; it does not wrap.
  - Decode priority: all-ones -> lit = 1, nibble = 0. All-zeros -> blank = 1, nibble = 0. Exact match to glyph k -> nibble = k. Otherwise glyph_err = 1, nibble = 0.
  - Decode result is in staging 1 cycle after the 40th bit.
  - Bits beyond 640 are not decoded; they only advance the saturating count.
- Control load (rs = 1): bits shift into a 32-bit register. No per-char decode.
- Latch (one cycle after latch is detected), with recorded rs = 0:
  - Total count == 640 and no err: copy staging to hex_data / blank_flags / lit_flags / glyph_err; pulse frame_stb.
  - Otherwise: pulse frame_err; outputs unchanged.
- Latch with recorded rs = 1:
  - Count == 32 and no err: ctrl_word <= register; pulse ctrl_stb.
  - Otherwise: pulse frame_err.
- After any latch: clear counts, err, char_idx := 15, shift register.
- Latch with count 0: no pulse at all.
- Reset-capable inputs:
  - Synced disp_reset_b = 0: abort any load, clear counts and staging. Held outputs keep their values.
  - reset_seen pulses once on the falling edge.
  - Shift edges are ignored while disp_reset_b = 0.
- Simultaneous events:
  - sclk_rise and latch in the same cycle: the bit is taken first, then the latch evaluates with the updated count.
  - reset dominates everything.
- Timing: input-to-output latency is SYNC_STAGES + 2 cycles from the ce_b rise to frame_stb.

Decomposition:
- Package hex_display_pkg:
  - Constants NUM_CHARS, DOTS_PER_CHAR, CTRL_BITS, FRAME_BITS = 640.
  - 16-entry 40-bit glyph ROM constant, identical to the driver's font:
    - '0' = 3E_51_49_45_3E; '1' = 00_42_7F_40_00; 'A' = 7E_09_09_09_7E; and so on.
  - A typedef for the decode result {nibble, blank, lit, err}.
- Sub-module hex_glyph_decode: purely combinational 40-bit -> decode result, so the driver bench can share it.

Test Plan:
- Driver power-up sequence: 640 zeros with rs = 0, latch, then 32 bits of 7F7F7F7F with rs = 1, latch -> frame_stb with blank_flags = FFFF, hex_data = 0; then ctrl_stb with ctrl_word = 32'h7F7F7F7F.
- Frame encoding 64'h0123_4567_89AB_CDEF, no blank/lit -> frame_stb; hex_data = 0123456789ABCDEF; blank/lit/glyph_err all 0.
- Char 5 dots forced to all ones and char 9 to all zeros -> lit_flags = 0020, blank_flags = 0200, hex_data nibbles 5 and 9 = 0.
- Char 0 = 40'h3E_51_49_45_3F (glyph '0' with one dot flipped) -> glyph_err = 0001.
- Latch after 639 bits -> frame_err pulse; hex_data keeps the previous value.
- disp_reset_b pulsed low after 200 bits, then a full valid frame -> reset_seen pulse, no frame_err, then a correct frame_stb.
